// File: rtl/gcm_pkg.sv
// gcm_pkg: shared widths, FIFO entry type and serializer states for the gcm output path.
package gcm_pkg;
    localparam int GCM_BLK_BITS   = 128;
    localparam int AXIS_WORD_BITS = 32;
    localparam int WORDS_PER_BLK  = GCM_BLK_BITS / AXIS_WORD_BITS;

    typedef struct packed {
        logic                    last;
        logic [GCM_BLK_BITS-1:0] blk;
    } gcm_out_entry_t;

    typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;
endpackage

// File: rtl/gcm_out_serializer_blk_fifo.sv
// blk_fifo: synchronous FIFO of gcm_out_entry_t with a combinational head view.
module blk_fifo
    import gcm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_push,
    input  logic           i_pop,
    input  gcm_out_entry_t i_data,
    output logic           o_full,
    output logic           o_empty,
    output logic [PTR_W:0] o_level,
    output gcm_out_entry_t o_head
);
    gcm_out_entry_t   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{PTR_W{1'b0}}, i_push} - {{PTR_W{1'b0}}, i_pop};
        end
    end

    // Storage needs no reset: an empty level makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = r_level == DEPTH[PTR_W:0];
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/gcm_out_serializer.sv
// gcm_out_serializer: buffers gcm result blocks and streams them MS word first on AXI4-Stream.
// Define GCM_OUT_BSWAP_EN to byte-reverse every output word for little-endian DMA memory.
module gcm_out_serializer
    import gcm_pkg::*;
#(
    parameter  int BLK_BITS   = GCM_BLK_BITS,
    parameter  int WORD_BITS  = AXIS_WORD_BITS,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BLK_BITS-1:0]  in_blk,
    input  logic                 in_store_blk,
    input  logic                 in_last,
    output logic [WORD_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic [LVL_W-1:0]     fifo_level
);
    localparam int WPB   = BLK_BITS / WORD_BITS;
    localparam int CNT_W = (WPB > 1) ? $clog2(WPB) : 1;

    ser_state_t           r_state;
    ser_state_t           w_next_state;
    logic [CNT_W-1:0]     r_word_cnt;
    logic [CNT_W-1:0]     w_word_cnt_nx;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_cnt_last;
    gcm_out_entry_t       w_entry;
    gcm_out_entry_t       w_head;
    logic [BLK_BITS-1:0]  w_blk_sh;
    logic [WORD_BITS-1:0] w_word;
    logic [WORD_BITS-1:0] w_word_out;

    assign w_entry = '{last: in_last, blk: in_blk};
    // A full FIFO still accepts a block when its head drains this same cycle.
    assign w_push  = in_store_blk && (!w_full || w_pop);

    blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_head  (w_head)
    );

    assign w_cnt_last = r_word_cnt == CNT_W'(WPB - 1);

    always_comb begin
        w_next_state  = r_state;
        w_word_cnt_nx = r_word_cnt;
        w_pop         = 1'b0;
        if (r_state == SER_IDLE) begin
            w_word_cnt_nx = '0;
            w_next_state  = w_empty ? SER_IDLE : SER_SEND;
        end else if (m_axis_tready) begin
            w_word_cnt_nx = w_cnt_last ? '0 : r_word_cnt + 1'b1;
            w_pop         = w_cnt_last;
            w_next_state  = (w_cnt_last && fifo_level == LVL_W'(1) && !in_store_blk) ? SER_IDLE : SER_SEND;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SER_IDLE;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_word_cnt <= w_word_cnt_nx;
            r_overflow <= r_overflow | (in_store_blk & w_full & ~w_pop);
        end
    end

    assign w_blk_sh = w_head.blk << (WORD_BITS * r_word_cnt);
    assign w_word   = w_blk_sh[BLK_BITS-1 -: WORD_BITS];

    always_comb begin
        w_word_out = w_word;
`ifdef GCM_OUT_BSWAP_EN
        for (int b = 0; b < WORD_BITS / 8; b++) w_word_out[8*b +: 8] = w_word[WORD_BITS-8-8*b +: 8];
`endif
    end

    assign m_axis_tvalid = r_state == SER_SEND;
    assign m_axis_tdata  = m_axis_tvalid ? w_word_out : '0;
    assign m_axis_tlast  = m_axis_tvalid && w_head.last && w_cnt_last;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_gcm_out_serializer.sv
// tb_gcm_out_serializer: scoreboard bench for the gcm output serializer.
module tb_gcm_out_serializer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in_blk = '0;
    logic         in_store_blk = 1'b0;
    logic         in_last = 1'b0;
    logic [31:0]  tdata;
    logic         tvalid;
    logic         tready = 1'b0;
    logic         tlast;
    logic         overflow;
    logic [2:0]   fifo_level;

    int total = 0;
    int bad = 0;
    logic [32:0] exp_q[$];

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] B3 = 128'h10203040_50607080_90a0b0c0_d0e0f000;
    localparam logic [127:0] B4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] B5 = 128'h55555555_aaaaaaaa_12121212_34343434;

    always #5 clk = ~clk;

    gcm_out_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .in_blk        (in_blk),
        .in_store_blk  (in_store_blk),
        .in_last       (in_last),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    function automatic logic [31:0] exp_word(input logic [127:0] b, input int k);
        logic [31:0] w;
        w = b[127-32*k -: 32];
`ifdef GCM_OUT_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic push_blk(input logic [127:0] b, input logic l, input bit keep);
        in_blk = b;
        in_last = l;
        in_store_blk = 1'b1;
        if (keep) for (int k = 0; k < 4; k++) exp_q.push_back({l && k == 3, exp_word(b, k)});
        @(posedge clk); #1;
        in_store_blk = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
        if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (tvalid !== 1'b0) begin bad++; $display("FAIL post_reset_tvalid got=%b exp=0", tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [32:0] e;
        logic [31:0] w[4];
        int got;
        bit started;
        tready = 1'b1;
        push_blk(B1, 1'b1, 1'b1);
        got = 0;
        started = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (tvalid) begin
                started = 1;
                e = exp_q.pop_front();
                w[got] = tdata;
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL single_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end else if (started) begin
                total++; bad++; $display("FAIL single_bubble got=tvalid0 exp=tvalid1");
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL single_count got=%0d exp=4", got); end
        total += 2;
`ifdef GCM_OUT_BSWAP_EN
        if (w[0] !== 32'h33221100) begin bad++; $display("FAIL single_first got=%h exp=33221100", w[0]); end
        if (w[3] !== 32'hffeeddcc) begin bad++; $display("FAIL single_lastword got=%h exp=ffeeddcc", w[3]); end
`else
        if (w[0] !== 32'h00112233) begin bad++; $display("FAIL single_first got=%h exp=00112233", w[0]); end
        if (w[3] !== 32'hccddeeff) begin bad++; $display("FAIL single_lastword got=%h exp=ccddeeff", w[3]); end
`endif
        @(negedge clk);
        total++;
        if (tvalid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        logic [32:0] e;
        int got;
        tready = 1'b0;
        push_blk(B2, 1'b1, 1'b1);
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, exp_q[0][31:0]})
                begin bad++; $display("FAIL stall_hold%0d got=%b%b_%h exp=10_%h", c, tvalid, tlast, tdata, exp_q[0][31:0]); end
            @(posedge clk); #1;
        end
        tready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (tvalid) begin
                e = exp_q.pop_front();
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL stall_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end else begin
                total++; bad++; $display("FAIL stall_bubble got=tvalid0 exp=tvalid1");
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", got); end
    endtask

    task automatic test_back_to_back;
        logic [32:0] e;
        int got;
        bit started;
        tready = 1'b1;
        push_blk(B3, 1'b0, 1'b1);
        push_blk(B4, 1'b1, 1'b1);
        got = 0;
        started = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            @(negedge clk);
            if (tvalid) begin
                started = 1;
                e = exp_q.pop_front();
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL b2b_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end else if (started) begin
                total++; bad++; $display("FAIL b2b_bubble at word %0d got=tvalid0 exp=tvalid1", got);
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
    endtask

    task automatic test_overflow;
        logic [32:0] e;
        int got;
        tready = 1'b0;
        push_blk(B1, 1'b0, 1'b1);
        push_blk(B2, 1'b1, 1'b1);
        push_blk(B3, 1'b0, 1'b1);
        push_blk(B4, 1'b1, 1'b1);
        @(negedge clk);
        total += 2;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level4 got=%0d exp=4", fifo_level); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        @(posedge clk); #1;
        push_blk(B5, 1'b1, 1'b0);
        @(negedge clk);
        total += 2;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        @(posedge clk); #1;
        tready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 16; c++) begin
            @(negedge clk);
            if (tvalid) begin
                e = exp_q.pop_front();
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL ovf_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end else begin
                total++; bad++; $display("FAIL ovf_bubble got=tvalid0 exp=tvalid1");
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", got); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (tvalid !== 1'b0) begin bad++; $display("FAIL ovf_extra_word got=%h exp=none", tdata); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total += 2;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", fifo_level); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [32:0] e;
        int got;
        tready = 1'b1;
        push_blk(B3, 1'b1, 1'b1);
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (tvalid) begin
                e = exp_q.pop_front();
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL mid_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total += 4;
        if (tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b exp=0", tvalid); end
        if (tlast !== 1'b0) begin bad++; $display("FAIL mid_tlast got=%b exp=0", tlast); end
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_blk(B4, 1'b0, 1'b1);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (tvalid) begin
                e = exp_q.pop_front();
                total++;
                if ({tlast, tdata} !== e) begin bad++; $display("FAIL restart_word%0d got=%b_%h exp=%b_%h", got, tlast, tdata, e[32], e[31:0]); end
                got++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL restart_count got=%0d exp=4", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
